bcd_to_binary_converter: RTL and testbench
==========================================

Name: bcd_to_binary_converter

Overview:
Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3 from each digit >= 8). Accepts a packed multi-digit BCD word through a start/busy/done handshake and returns the binary value after a fixed latency. It sits on the input side of the number-formatting path and undoes the binary-to-BCD conversion used for display and output. Invalid BCD digits are detected and flagged instead of being converted.

Parameters:
DIGITS, 2, number of BCD digits in bcd_input (>= 1)
BIN_WIDTH, 7, width of binary_output; must be >= ceil(log2(10^DIGITS)); elaboration-time check fails otherwise

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a conversion; sampled only when busy=0
bcd_input  input  4*DIGITS  packed BCD, digit 0 in [3:0]; sampled on the accepting edge
busy  output  1  high while a conversion is in flight
done  output  1  one-cycle pulse; binary_output and error valid in that cycle
binary_output  output  BIN_WIDTH  converted value; held until the next accepted start
error  output  1  set with done when any input nibble > 9; held with binary_output

Behaviour:
- Reset (async, any time, including mid-conversion): state=IDLE, busy=0, done=0, binary_output=0, error=0, internal shift registers and counter=0. In-flight conversion discarded, no done.
- States: IDLE, CONV, FINISH.
- IDLE: start=1 at edge E0 -> validity check on bcd_input.
  - All nibbles <= 9: load the BCD shift register, clear the binary accumulator, counter=0, busy=1, go to CONV.
  - Any nibble > 9: go to FINISH directly; binary result forced to 0, error result=1, busy=1.
- CONV, one step per clock: shift {bcd_reg, bin_acc} right by 1 (LSB of bcd_reg enters MSB of bin_acc). Then, for each digit of the shifted bcd_reg, subtract 3 if the digit >= 8. Correction is combinational within the same cycle as the shift. counter increments. After BIN_WIDTH steps go to FINISH.
- FINISH: register binary_output=bin_acc (or 0 on error) and error. done=1 for exactly this cycle; busy=0 on the same edge. Return to IDLE.
- Latency, valid input: done is high in the cycle beginning at edge E0+BIN_WIDTH+1 (8 cycles at defaults). Invalid input: done at E0+1.
- A start pulse while busy=1 or in the FINISH cycle is ignored; no queuing. A start in the cycle after done is accepted normally.
- Back-to-back throughput: one conversion per BIN_WIDTH+2 cycles.
- Width rules: bin_acc is BIN_WIDTH bits. Because of the parameter check, the result never truncates.
- done and error are never X after reset. binary_output changes only in the FINISH cycle.

Decomposition:
- Shared package holds the state enum (IDLE/CONV/FINISH), the BCD digit width constant (4), the correction threshold (8) and correction value (3), and a min-width function ceil(log2(10^DIGITS)) used by the parameter check.
- One natural sub-module, bcd_digit_correct: a combinational per-digit "if >= 8 then -3" unit, instantiated DIGITS times via generate.

Test Plan:
- Reset, then start with bcd_input=8'h99 -> busy for 7 steps; done after 8 cycles; binary_output=7'd99, error=0.
- bcd_input=8'h00, then 8'h42, then 8'h07 back-to-back, each start issued the cycle after done -> outputs 0, 42, 7; done pulses spaced 9 cycles apart.
- bcd_input=8'h5A -> done 1 cycle after start; error=1, binary_output=0. The next conversion of 8'h10 -> 10, error=0.
- start asserted with 8'h12, then start with 8'h34 re-pulsed on cycle 3 while busy -> single done with 12; the second request is ignored.
- rst asserted asynchronously mid-CONV (cycle 4 of 8'h77) -> busy, done, binary_output and error go to 0 immediately; no done pulse afterwards. A fresh 8'h77 -> 77.
- Exhaustive sweep of 00..99 plus all invalid nibble combinations, with DIGITS=3 / BIN_WIDTH=10 as a second configuration (999 -> 10'd999) -> matches the behavioural model; error set exactly for invalid inputs.

Source files
------------

// File: rtl/bcd_to_binary_converter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_to_binary_converter_pkg: shared types and constants for the BCD to   |
// | binary converter. Revision: 1.0                                          |
// +--------------------------------------------------------------------------+
package bcd_to_binary_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int               BCD_DIGIT_W   = 4;
  localparam logic [3:0]       BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0]       CORR_THRESH   = 4'd8;
  localparam logic [3:0]       CORR_VALUE    = 4'd3;

  // ceil(log2(10**digits)): bits needed to hold any DIGITS-digit decimal value.
  function automatic int min_bin_width(input int digits);
    longint unsigned span;
    int              width;
    span  = 64'd1;
    width = 0;
    for (int i = 0; i < digits; i++) begin
      span = span * 64'd10;
    end
    for (int b = 0; b < 64; b++) begin
      if ((64'd1 << b) < span) begin
        width = b + 1;
      end
    end
    return width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_binary_converter_digit_correct.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_digit_correct: one reverse double-dabble digit fix-up, subtracting   |
// | three from a digit that reached eight or more. Revision: 1.0             |
// +--------------------------------------------------------------------------+
module bcd_digit_correct
  import bcd_to_binary_converter_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= CORR_THRESH) begin
      o_digit = i_digit - CORR_VALUE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_to_binary_converter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_to_binary_converter: sequential packed-BCD to binary converter using |
// | reverse double-dabble, with invalid-digit flagging. Revision: 1.0        |
// +--------------------------------------------------------------------------+
module bcd_to_binary_converter
  import bcd_to_binary_converter_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int BIN_WIDTH = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_input,
  output logic                          busy,
  output logic                          done,
  output logic [BIN_WIDTH-1:0]          binary_output,
  output logic                          error
);

  localparam int                BCD_W     = BCD_DIGIT_W * DIGITS;
  localparam int                CNT_W     = $clog2(BIN_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(BIN_WIDTH - 1);

  generate
    if (DIGITS < 1) begin : g_digits_check
      $error("DIGITS must be at least 1");
    end
    if (BIN_WIDTH < min_bin_width(DIGITS)) begin : g_width_check
      $error("BIN_WIDTH too narrow for DIGITS decimal digits");
    end
  endgenerate

  state_e                 state_q, state_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [BIN_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [BIN_WIDTH-1:0]   bin_out_q, bin_out_d;
  logic                   error_q, error_d;
  logic                   err_pend_q, err_pend_d;

  logic                       w_invalid;
  logic [BCD_W+BIN_WIDTH-1:0] w_shift;
  logic [BCD_W-1:0]           w_bcd_sh;
  logic [BCD_W-1:0]           w_bcd_corr;
  logic [BIN_WIDTH-1:0]       w_acc_sh;

  always_comb begin
    w_invalid = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_input[d*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) begin
        w_invalid = 1'b1;
      end
    end
  end

  // The BCD LSB falls into the accumulator MSB; digits are then fixed up.
  assign w_shift  = {bcd_q, acc_q} >> 1;
  assign w_bcd_sh = w_shift[BIN_WIDTH +: BCD_W];
  assign w_acc_sh = w_shift[BIN_WIDTH-1:0];

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_correct u_corr (
        .i_digit (w_bcd_sh[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit (w_bcd_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bin_out_d  = bin_out_q;
    error_d    = error_q;
    err_pend_d = err_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          acc_d  = '0;
          cnt_d  = '0;
          if (w_invalid) begin
            bcd_d      = '0;
            err_pend_d = 1'b1;
            state_d    = ST_FINISH;
          end else begin
            bcd_d      = bcd_input;
            err_pend_d = 1'b0;
            state_d    = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        bcd_d = w_bcd_corr;
        acc_d = w_acc_sh;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        bin_out_d = err_pend_q ? '0 : acc_q;
        error_d   = err_pend_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bcd_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bin_out_q  <= '0;
      error_q    <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bin_out_q  <= bin_out_d;
      error_q    <= error_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign binary_output = bin_out_q;
  assign error         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary_converter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcd_to_binary_converter: scoreboard bench for two converter configs   |
// | (2 digits / 7 bits and 3 digits / 10 bits). Revision: 1.0                |
// +--------------------------------------------------------------------------+
module tb_bcd_to_binary_converter;

  typedef struct {
    int val;
    bit err;
    int due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start0, start1;
  logic [7:0]  bcd0;
  logic [11:0] bcd1;
  logic        busy0, busy1, done0, done1, error0, error1;
  logic [6:0]  bin0;
  logic [9:0]  bin1;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sbq [2][$];
  int   next_ok [2];
  int   k0 [2];
  int   due_last [2];
  int   last_val [2];
  bit   last_err [2];

  bcd_to_binary_converter #(.DIGITS(2), .BIN_WIDTH(7)) u_dut0 (
    .clk (clk), .rst (rst), .start (start0), .bcd_input (bcd0),
    .busy (busy0), .done (done0), .binary_output (bin0), .error (error0)
  );

  bcd_to_binary_converter #(.DIGITS(3), .BIN_WIDTH(10)) u_dut1 (
    .clk (clk), .rst (rst), .start (start1), .bcd_input (bcd1),
    .busy (busy1), .done (done1), .binary_output (bin1), .error (error1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Decimal meaning of the packed word; any digit above nine makes it an error.
  function automatic void ref_conv(input logic [11:0] b, input int d,
                                   output int val, output bit err);
    int nib;
    val = 0;
    err = 1'b0;
    for (int i = d - 1; i >= 0; i--) begin
      nib = int'((b >> (4 * i)) & 12'hF);
      if (nib > 9) err = 1'b1;
      val = val * 10 + nib;
    end
    if (err) val = 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      sbq[i].delete();
      next_ok[i]  = 0;
      k0[i]       = 0;
      due_last[i] = 0;
      last_val[i] = 0;
      last_err[i] = 1'b0;
    end
  endtask

  task automatic model_issue(input int id, input logic [11:0] b);
    int   v;
    bit   e;
    int   lat;
    exp_t x;
    if (cyc >= next_ok[id]) begin
      ref_conv(b, (id == 0) ? 2 : 3, v, e);
      lat          = e ? 1 : (((id == 0) ? 7 : 10) + 1);
      k0[id]       = cyc + 1;
      due_last[id] = cyc + 1 + lat;
      next_ok[id]  = due_last[id];
      x.val = v;
      x.err = e;
      x.due = due_last[id];
      sbq[id].push_back(x);
    end
  endtask

  // Called at a falling edge; drives both start ports for one clock.
  task automatic drive(input bit s0, input logic [11:0] b0,
                       input bit s1, input logic [11:0] b1);
    start0 = s0;
    bcd0   = b0[7:0];
    start1 = s1;
    bcd1   = b1;
    if (s0) model_issue(0, b0);
    if (s1) model_issue(1, b1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int id);
    while (cyc < next_ok[id]) drive(1'b0, 12'h0, 1'b0, 12'h0);
  endtask

  task automatic monitor(input int id, input bit dn, input bit bz,
                         input int out, input bit er);
    exp_t e;
    chk($sformatf("d%0d_busy", id), int'(bz),
        int'((cyc >= k0[id]) && (cyc < due_last[id])));
    if (sbq[id].size() > 0 && sbq[id][0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL d%0d_missing_done actual=none required=%0d at cycle %0d",
               id, sbq[id][0].val, sbq[id][0].due);
      void'(sbq[id].pop_front());
    end
    if (dn) begin
      if (sbq[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d%0d_unexpected_done actual=%0d required=no_done", id, out);
      end else begin
        e = sbq[id].pop_front();
        chk($sformatf("d%0d_value", id), out, e.val);
        chk($sformatf("d%0d_error", id), int'(er), int'(e.err));
        chk($sformatf("d%0d_done_cycle", id), cyc, e.due);
        last_val[id] = e.val;
        last_err[id] = e.err;
      end
    end else begin
      chk($sformatf("d%0d_hold_value", id), out, last_val[id]);
      chk($sformatf("d%0d_hold_error", id), int'(er), int'(last_err[id]));
    end
  endtask

  always @(negedge clk) if (!rst) monitor(0, done0, busy0, int'(bin0), error0);
  always @(negedge clk) if (!rst) monitor(1, done1, busy1, int'(bin1), error1);

  initial begin
    int i0;
    int i1;
    bit s0;
    bit s1;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    bcd0   = '0;
    bcd1   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_bin0", int'(bin0), 0);
    chk("rst_err0", int'(error0), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_bin1", int'(bin1), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // 99, then back-to-back 00 / 42 / 07, then invalid 5A followed by 10
    drive(1'b1, 12'h099, 1'b0, 12'h0);
    wait_idle(0);
    drive(1'b1, 12'h000, 1'b0, 12'h0);
    wait_idle(0);
    drive(1'b1, 12'h042, 1'b0, 12'h0);
    wait_idle(0);
    drive(1'b1, 12'h007, 1'b0, 12'h0);
    wait_idle(0);
    drive(1'b1, 12'h05A, 1'b0, 12'h0);
    wait_idle(0);
    drive(1'b1, 12'h010, 1'b0, 12'h0);
    wait_idle(0);

    // A second request while busy must be dropped.
    drive(1'b1, 12'h012, 1'b0, 12'h0);
    drive(1'b0, 12'h000, 1'b0, 12'h0);
    drive(1'b1, 12'h034, 1'b0, 12'h0);
    wait_idle(0);
    repeat (12) drive(1'b0, 12'h0, 1'b0, 12'h0);

    // Asynchronous reset in the middle of a conversion.
    drive(1'b1, 12'h077, 1'b0, 12'h0);
    repeat (3) drive(1'b0, 12'h0, 1'b0, 12'h0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy0), 0);
    chk("async_rst_done", int'(done0), 0);
    chk("async_rst_bin", int'(bin0), 0);
    chk("async_rst_err", int'(error0), 0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (12) drive(1'b0, 12'h0, 1'b0, 12'h0);
    drive(1'b1, 12'h077, 1'b0, 12'h0);
    wait_idle(0);

    // Every input word on both configurations, issued as fast as accepted.
    i0 = 0;
    i1 = 0;
    while (i0 < 256 || i1 < 4096) begin
      s0 = (i0 < 256) && (cyc >= next_ok[0]);
      s1 = (i1 < 4096) && (cyc >= next_ok[1]);
      drive(s0, 12'(i0), s1, 12'(i1));
      if (s0) i0++;
      if (s1) i1++;
    end
    wait_idle(0);
    wait_idle(1);

    // Random starts at random times, including while busy or finishing.
    repeat (600) begin
      drive($urandom_range(0, 2) == 0, 12'($urandom),
            $urandom_range(0, 2) == 0, 12'($urandom));
    end
    repeat (20) drive(1'b0, 12'h0, 1'b0, 12'h0);
    chk("drain_q0", sbq[0].size(), 0);
    chk("drain_q1", sbq[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
